// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
// Pure declarations: no state and no latency of its own.
// No flow control lives here.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of ripple passes needed to cover the whole operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; at least one bit even for a single-pass config.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_unit_chunk_adder.sv
// One CHUNK-bit ripple slice: s_c = a_c + b_c + cin.
// Combinational, zero latency.
// No flow control; the enclosing unit sequences it.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             cin,
  output logic [CHUNK-1:0] s_c,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  // Widened add so the carry out falls into the extra top bit.
  assign full = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, cin};

  assign s_c  = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // The MSB sum bit is a^b^carry_in, so the carry into it can be recovered.
  assign c_msb_in = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle WIDTH-bit add/subtract through one shared CHUNK-bit ripple slice.
// Latency: WIDTH/CHUNK cycles from accept to out_valid; one op per WIDTH/CHUNK+2 cycles.
// Backpressure: result and flags held in DONE until out_ready; in_ready only in IDLE.
module seq_addsub_unit
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_addsub_unit: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] sum_d;

  // Route the chunk selected by the counter into the shared slice.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        a_c = a_q[k*CHUNK +: CHUNK];
        b_c = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a_c      (a_c),
    .b_c      (b_c),
    .cin      (carry_q),
    .s_c      (s_c),
    .cout     (c_out),
    .c_msb_in (c_msb)
  );

  // Result with the current chunk merged in, so zero sees the full word on the last pass.
  always_comb begin
    sum_d = sum_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        sum_d[k*CHUNK +: CHUNK] = s_c;
      end
    end
  end

  // Control FSM plus operand, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (sub == OP_SUB) ? ~b : b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= c_out;
          if (cnt_q == LAST) begin
            cout_q  <= c_out;
            ovf_q   <= c_msb ^ c_out;
            zero_q  <= ~|sum_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/seq_addsub_unit.md
Name: seq_addsub_unit

Overview:
- Parametrised, multi-cycle integer adder/subtractor for the FP_Add datapath, e.g. mantissa add and exponent difference.
- Processes WIDTH-bit operands CHUNK bits per cycle through one shared CHUNK-bit ripple slice. Carry is held in a register between chunks.
- Valid/ready handshakes on both sides; reports carry-out, signed overflow and zero flags.
- Generalises the fixed 8-bit combinational a + ~b + cin adder: width, chunk size and mode are selectable.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept an operand bundle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = a+b+cin, 1 = a+~b+cin.
- cin  in  1  carry-in; sub=1 with cin=1 gives a-b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; in sub mode 1 means no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, chunk counter=0, carry register=0. sum, cout, ovf, zero and out_valid are all 0. in_ready=1 (decoded from IDLE) while in reset.
- FSM states IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready, capture a, b (b inverted when sub=1) and cin into the carry register; clear the counter; go to RUN.
- RUN: each cycle add chunk k of a and b_eff plus the carry register; write the CHUNK result bits into sum[k*CHUNK +: CHUNK]; update the carry register; increment k.
  - On the last chunk (k = NCHUNK-1, NCHUNK = WIDTH/CHUNK), latch cout = carry out of the MSB.
  - Latch ovf = carry into MSB XOR carry out of MSB.
  - Latch zero from the complete result; go to DONE.
- Latency: operands captured at edge E0; out_valid is high after edge E(NCHUNK). CHUNK=WIDTH gives 1-cycle latency.
- DONE: sum and flags held stable while out_valid && !out_ready (arbitrary backpressure length). On out_valid&&out_ready, go to IDLE; in_ready rises the next cycle. There is no same-cycle accept, so peak throughput is one op per NCHUNK+2 cycles.
- Outside IDLE: in_valid and in_ready are ignored, and operands captured earlier must not change.
- sum is undefined-free but partially updated during RUN; consumers sample only on out_valid.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the in-flight result is discarded and no out_valid pulse occurs.
- The counter is ceil(log2(NCHUNK)) bits wide, minimum 1; it never wraps, because the final chunk forces DONE.

Decomposition:
- Package seq_addsub_pkg holds:
  - state typedef enum {IDLE, RUN, DONE};
  - op constants OP_ADD=1'b0, OP_SUB=1'b1;
  - function nchunk(WIDTH, CHUNK).
- Sub-module chunk_adder (combinational, parameter CHUNK):
  - inputs a_c, b_c, cin; outputs s_c, cout, c_msb_in (carry into the MSB, for ovf).
  - Instantiated once in seq_addsub_unit.
- Elaboration-time assertion that WIDTH % CHUNK == 0.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
- Add: a=0x000000FF, b=0x00000001, sub=0, cin=0 -> sum=0x00000100, cout=0, ovf=0, zero=0; out_valid 4 cycles after accept.
- Sub: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then a=7, b=7 -> sum=0, cout=1, zero=1.
- Overflow:
  - 0x7FFFFFFF + 1 (add) -> sum=0x80000000, ovf=1, cout=0.
  - 0x80000000 - 1 (sub, cin=1) -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum and flags stable, in_ready=0, in_valid ignored. Release -> in_ready=1 one cycle after the handshake.
- Reset mid-RUN: assert rst_n=0 at chunk 2 -> out_valid=0, sum=0, in_ready=1 immediately. A new op after release completes correctly.
- Configs CHUNK=32 and CHUNK=1: random add/sub vs reference model -> exact match; latency 1 and 32 cycles respectively.
